// File: rtl/hilo_mult_unit_pkg.sv
// Shared definitions for the HI/LO multiply unit: ALU-control opcodes, FSM states, width.
package hilo_pkg;

  localparam int WIDTH = 32;

  localparam logic [4:0] MULT = 5'b00101;
  localparam logic [4:0] MADD = 5'b01100;
  localparam logic [4:0] MSUB = 5'b01101;
  localparam logic [4:0] MUL  = 5'b11000;
  localparam logic [4:0] MTHI = 5'b10001;
  localparam logic [4:0] MTLO = 5'b10011;
  localparam logic [4:0] MFHI = 5'b10000;
  localparam logic [4:0] MFLO = 5'b10010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_FIX,
    ST_DONE
  } state_e;

endpackage

// File: rtl/hilo_mult_unit_if.sv
// EX-stage bundle between the pipeline and the HI/LO unit.
interface hilo_mult_unit_if #(parameter int WIDTH = 32);
  logic             Start;
  logic [4:0]       ALUCtl;
  logic             HiLoWrite;
  logic             Flush;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Busy;
  logic             Stall;
  logic             Done;
  logic [WIDTH-1:0] MulLo;
  logic [WIDTH-1:0] Hi;
  logic [WIDTH-1:0] Lo;
  logic [WIDTH-1:0] MoveOut;

  modport slave (
    input  Start, ALUCtl, HiLoWrite, Flush, A, B,
    output Busy, Stall, Done, MulLo, Hi, Lo, MoveOut
  );

  modport master (
    output Start, ALUCtl, HiLoWrite, Flush, A, B,
    input  Busy, Stall, Done, MulLo, Hi, Lo, MoveOut
  );
endinterface

// File: rtl/hilo_mult_unit_mult_iter_core.sv
// Unsigned iterative shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle.
module mult_iter_core #(
  parameter int WIDTH          = 32,
  parameter int BITS_PER_CYCLE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_go,
  input  logic [WIDTH-1:0]     i_mcand,
  input  logic [WIDTH-1:0]     i_mplier,
  output logic                 o_ready,
  output logic [2*WIDTH-1:0]   o_product
);

  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  localparam int CNT_W = $clog2(STEPS) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_partial;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_partial = '0;
    for (int j = 0; j < BITS_PER_CYCLE; j++) begin
      if (r_mplier[j]) w_partial = w_partial + (r_mcand << j);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_go) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_mcand};
      r_mplier <= i_mplier;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_prod   <= r_prod + w_partial;
      r_mcand  <= r_mcand << BITS_PER_CYCLE;
      r_mplier <= r_mplier >> BITS_PER_CYCLE;
      r_cnt    <= r_cnt + 1'b1;
      if (o_ready) r_run <= 1'b0;
    end
  end

  // High in the cycle whose closing edge retires the last multiplier bits.
  assign o_ready   = r_run && (r_cnt == CNT_W'(STEPS - 1));
  assign o_product = r_prod;

endmodule

// File: rtl/hilo_mult_unit.sv
// HI/LO execution unit: owns HI/LO, sequences multiplies on mult_iter_core, serves moves.
module hilo_mult_unit #(
  parameter int BITS_PER_CYCLE = 2,
  parameter int WIDTH          = hilo_pkg::WIDTH
) (
  input  logic             Clk,
  input  logic             Rst,
  hilo_mult_unit_if.slave  bus
);
  import hilo_pkg::*;

  state_e               r_state;
  logic [4:0]           r_op;
  logic                 r_neg;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_mullo;

  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_go;
  logic                 w_ready;
  logic [WIDTH-1:0]     w_abs_a;
  logic [WIDTH-1:0]     w_abs_b;
  logic [2*WIDTH-1:0]   w_product;
  logic [2*WIDTH-1:0]   w_signed;
  logic [2*WIDTH-1:0]   w_acc;
  logic [2*WIDTH-1:0]   w_result;

  assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) &&
                    bus.Start && bus.HiLoWrite && !bus.Flush;
  assign w_is_mul = (bus.ALUCtl == MULT) || (bus.ALUCtl == MADD) ||
                    (bus.ALUCtl == MSUB) || (bus.ALUCtl == MUL);
  assign w_go     = w_accept && w_is_mul;

  // Magnitudes are unsigned, so -2^WIDTH-1 maps cleanly onto its top bit.
  assign w_abs_a = bus.A[WIDTH-1] ? (~bus.A + 1'b1) : bus.A;
  assign w_abs_b = bus.B[WIDTH-1] ? (~bus.B + 1'b1) : bus.B;

  mult_iter_core #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_core (
    .clk       (Clk),
    .rst_n     (Rst),
    .i_go      (w_go),
    .i_mcand   (w_abs_a),
    .i_mplier  (w_abs_b),
    .o_ready   (w_ready),
    .o_product (w_product)
  );

  assign w_signed = r_neg ? (~w_product + 1'b1) : w_product;
  assign w_acc    = {r_hi, r_lo};

  always_comb begin
    w_result = w_signed;
    if (r_op == MADD)      w_result = w_acc + w_signed;
    else if (r_op == MSUB) w_result = w_acc - w_signed;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= ST_IDLE;
      r_op    <= MULT;
      r_neg   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_mullo <= '0;
    end else if (bus.Flush) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          r_state <= ST_IDLE;
          if (w_accept) begin
            case (bus.ALUCtl)
              MTHI: r_hi <= bus.A;
              MTLO: r_lo <= bus.A;
              MULT, MADD, MSUB, MUL: begin
                r_op    <= bus.ALUCtl;
                r_neg   <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
                r_state <= ST_MUL;
              end
              default: ;
            endcase
          end
        end
        ST_MUL: if (w_ready) r_state <= ST_FIX;
        ST_FIX: begin
          {r_hi, r_lo} <= w_result;
          r_mullo      <= w_signed[WIDTH-1:0];
          r_state      <= ST_DONE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.Busy    = (r_state == ST_MUL) || (r_state == ST_FIX);
  assign bus.Stall   = bus.Start && bus.Busy;
  assign bus.Done    = (r_state == ST_DONE);
  assign bus.Hi      = r_hi;
  assign bus.Lo      = r_lo;
  assign bus.MulLo   = r_mullo;
  assign bus.MoveOut = (bus.ALUCtl == MFHI) ? r_hi :
                       (bus.ALUCtl == MFLO) ? r_lo : '0;

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Self-checking bench for hilo_mult_unit: cycle-level reference model plus directed literal checks.
module tb_hilo_mult_unit;

  localparam logic [4:0] OP_MULT = 5'b00101;
  localparam logic [4:0] OP_MADD = 5'b01100;
  localparam logic [4:0] OP_MSUB = 5'b01101;
  localparam logic [4:0] OP_MUL  = 5'b11000;
  localparam logic [4:0] OP_MTHI = 5'b10001;
  localparam logic [4:0] OP_MTLO = 5'b10011;
  localparam logic [4:0] OP_MFHI = 5'b10000;
  localparam logic [4:0] OP_MFLO = 5'b10010;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  hilo_mult_unit_if #(.WIDTH(32)) bus ();

  hilo_mult_unit #(.BITS_PER_CYCLE(2), .WIDTH(32)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: age counts cycles since a multiply was accepted (1..17 busy, 18 done).
  logic [31:0] m_hi = '0, m_lo = '0, m_mullo = '0, m_a = '0, m_b = '0;
  logic [4:0]  m_op = OP_MULT;
  int          m_age = 0;

  function automatic logic [63:0] sprod(input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic model_step();
    logic [63:0] p, acc;
    if (!Rst) begin
      m_hi = '0; m_lo = '0; m_mullo = '0; m_age = 0;
    end else if (bus.Flush) begin
      m_age = 0;
    end else if (m_age >= 1 && m_age <= 16) begin
      m_age++;
    end else if (m_age == 17) begin
      p   = sprod(m_a, m_b);
      acc = {m_hi, m_lo};
      if (m_op == OP_MADD)      acc = acc + p;
      else if (m_op == OP_MSUB) acc = acc - p;
      else                      acc = p;
      {m_hi, m_lo} = acc;
      m_mullo = p[31:0];
      m_age = 18;
    end else begin
      m_age = 0;
      if (bus.Start && bus.HiLoWrite) begin
        case (bus.ALUCtl)
          OP_MTHI: m_hi = bus.A;
          OP_MTLO: m_lo = bus.A;
          OP_MULT, OP_MADD, OP_MSUB, OP_MUL: begin
            m_op = bus.ALUCtl; m_a = bus.A; m_b = bus.B; m_age = 1;
          end
          default: ;
        endcase
      end
    end
  endtask

  always @(posedge Clk) begin
    logic        e_busy;
    logic [31:0] e_move;
    model_step();
    #1;
    e_busy = (m_age >= 1 && m_age <= 17);
    e_move = (bus.ALUCtl == OP_MFHI) ? m_hi : (bus.ALUCtl == OP_MFLO) ? m_lo : 32'h0;
    check("busy",    64'(bus.Busy),    64'(e_busy));
    check("done",    64'(bus.Done),    64'(m_age == 18));
    check("stall",   64'(bus.Stall),   64'(bus.Start && e_busy));
    check("hi",      64'(bus.Hi),      64'(m_hi));
    check("lo",      64'(bus.Lo),      64'(m_lo));
    check("mullo",   64'(bus.MulLo),   64'(m_mullo));
    check("moveout", 64'(bus.MoveOut), 64'(e_move));
  end

  task automatic idle_inputs();
    bus.Start = 1'b0; bus.ALUCtl = 5'b0; bus.HiLoWrite = 1'b0; bus.Flush = 1'b0;
  endtask

  task automatic move(input logic [4:0] op, input logic [31:0] a);
    @(negedge Clk);
    bus.Start = 1'b1; bus.HiLoWrite = 1'b1; bus.ALUCtl = op; bus.A = a;
    @(negedge Clk);
    idle_inputs();
  endtask

  // Issues a multiply and returns in its DONE cycle; lat is the cycle index of Done.
  task automatic run_mul(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_n);
    @(negedge Clk);
    bus.Start = 1'b1; bus.HiLoWrite = 1'b1; bus.ALUCtl = op; bus.A = a; bus.B = b;
    @(posedge Clk); #1;
    lat = 1; busy_n = int'(bus.Busy);
    @(negedge Clk);
    idle_inputs(); bus.A = $urandom(); bus.B = $urandom();
    while (!bus.Done && lat < 40) begin
      @(posedge Clk); #1;
      lat++; busy_n += int'(bus.Busy);
    end
    if (!bus.Done) check("done_timeout", 64'(lat), 64'd18);
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  function automatic logic [4:0] rnd_op();
    case ($urandom_range(0, 9))
      0: return OP_MULT;
      1: return OP_MADD;
      2: return OP_MSUB;
      3: return OP_MUL;
      4: return OP_MTHI;
      5: return OP_MTLO;
      6: return OP_MFHI;
      7: return OP_MFLO;
      default: return 5'($urandom());
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat, busy_n, stall_n, done_n;
    idle_inputs(); bus.A = '0; bus.B = '0;

    // Reset state
    repeat (2) @(posedge Clk);
    #1;
    check("rst_hi", 64'(bus.Hi), 64'h0);
    check("rst_lo", 64'(bus.Lo), 64'h0);
    check("rst_mullo", 64'(bus.MulLo), 64'h0);
    check("rst_busy", 64'(bus.Busy), 64'h0);
    check("rst_done", 64'(bus.Done), 64'h0);
    @(negedge Clk); Rst = 1'b1;

    // mult 7 x -3
    run_mul(OP_MULT, 32'd7, 32'hFFFF_FFFD, lat, busy_n);
    check("mult_lat", 64'(lat), 64'd18);
    check("mult_busy_cycles", 64'(busy_n), 64'd17);
    check("mult_hi", 64'(bus.Hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(bus.Lo), 64'hFFFF_FFEB);
    check("mult_mullo", 64'(bus.MulLo), 64'hFFFF_FFEB);

    // mthi/mtlo then madd, msub
    move(OP_MTHI, 32'h1);
    move(OP_MTLO, 32'hFFFF_FFFF);
    run_mul(OP_MADD, 32'd1, 32'd1, lat, busy_n);
    check("madd_hi", 64'(bus.Hi), 64'h2);
    check("madd_lo", 64'(bus.Lo), 64'h0);
    run_mul(OP_MSUB, 32'd2, 32'd3, lat, busy_n);
    check("msub_hi", 64'(bus.Hi), 64'h1);
    check("msub_lo", 64'(bus.Lo), 64'hFFFF_FFFA);

    // most-negative squared, then mfhi in the DONE cycle
    run_mul(OP_MULT, 32'h8000_0000, 32'h8000_0000, lat, busy_n);
    check("minneg_hi", 64'(bus.Hi), 64'h4000_0000);
    check("minneg_lo", 64'(bus.Lo), 64'h0);
    #2;
    bus.Start = 1'b1; bus.HiLoWrite = 1'b0; bus.ALUCtl = OP_MFHI;
    #1;
    check("mfhi_done_move", 64'(bus.MoveOut), 64'h4000_0000);
    check("mfhi_done_stall", 64'(bus.Stall), 64'h0);
    @(negedge Clk); idle_inputs();

    // mflo issued in cycle 5 of a multiply stalls until DONE
    @(negedge Clk);
    bus.Start = 1'b1; bus.HiLoWrite = 1'b1; bus.ALUCtl = OP_MULT; bus.A = 32'd5; bus.B = 32'd9;
    @(negedge Clk); idle_inputs();
    repeat (4) @(negedge Clk);
    bus.Start = 1'b1; bus.ALUCtl = OP_MFLO;
    #1;
    stall_n = int'(bus.Stall);
    for (int i = 0; i < 40 && bus.Stall; i++) begin
      @(posedge Clk); #1;
      if (bus.Stall) stall_n++;
    end
    check("mflo_stall_cycles", 64'(stall_n), 64'd13);
    check("mflo_done", 64'(bus.Done), 64'h1);
    check("mflo_move", 64'(bus.MoveOut), 64'h2D);
    @(negedge Clk); idle_inputs();

    // Flush in MUL cycle 8 leaves HI/LO alone and never pulses Done
    move(OP_MTHI, 32'h1234_5678);
    move(OP_MTLO, 32'h9ABC_DEF0);
    bus.Start = 1'b1; bus.HiLoWrite = 1'b1; bus.ALUCtl = OP_MULT; bus.A = 32'd3; bus.B = 32'd4;
    @(negedge Clk); idle_inputs();
    repeat (7) @(negedge Clk);
    bus.Flush = 1'b1;
    @(negedge Clk); bus.Flush = 1'b0;
    check("flush_busy", 64'(bus.Busy), 64'h0);
    check("flush_hi", 64'(bus.Hi), 64'h1234_5678);
    check("flush_lo", 64'(bus.Lo), 64'h9ABC_DEF0);
    done_n = 0;
    repeat (20) begin
      @(posedge Clk); #1;
      if (bus.Done) done_n++;
    end
    check("flush_no_done", 64'(done_n), 64'h0);

    // Asynchronous reset mid-MUL
    @(negedge Clk);
    bus.Start = 1'b1; bus.HiLoWrite = 1'b1; bus.ALUCtl = OP_MADD; bus.A = 32'd11; bus.B = 32'd13;
    @(negedge Clk); idle_inputs();
    repeat (3) @(negedge Clk);
    #1 Rst = 1'b0;
    #1;
    check("arst_hi", 64'(bus.Hi), 64'h0);
    check("arst_lo", 64'(bus.Lo), 64'h0);
    check("arst_mullo", 64'(bus.MulLo), 64'h0);
    check("arst_busy", 64'(bus.Busy), 64'h0);
    @(negedge Clk); Rst = 1'b1;

    // Back-to-back: mul accepted in the DONE cycle of a mult
    run_mul(OP_MULT, 32'hFFFF_FFFF, 32'd2, lat, busy_n);
    check("b2b_first_lo", 64'(bus.Lo), 64'hFFFF_FFFE);
    run_mul(OP_MUL, 32'd6, 32'd7, lat, busy_n);
    check("b2b_lat", 64'(lat), 64'd18);
    check("b2b_mullo", 64'(bus.MulLo), 64'h2A);
    check("b2b_hi", 64'(bus.Hi), 64'h0);

    // Randomized traffic against the model
    repeat (1500) begin
      @(negedge Clk);
      bus.Start     = ($urandom_range(0, 2) != 0);
      bus.ALUCtl    = rnd_op();
      bus.HiLoWrite = ($urandom_range(0, 5) != 0);
      bus.Flush     = ($urandom_range(0, 59) == 0);
      bus.A         = rnd_val();
      bus.B         = rnd_val();
    end
    @(negedge Clk); idle_inputs();
    repeat (25) @(negedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
